// File: rtl/execute_mdu.sv
// Multiply/divide execute unit: forwarded-operand capture, pipelined multiply,
// restoring divider with sign fix-up, and a held result until the consumer takes it.
module execute_mdu #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned NUM_FWD = 2,
    parameter int unsigned MUL_LAT = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [2:0]                     mdu_op,
    input  logic [XLEN-1:0]                rs1,
    input  logic [XLEN-1:0]                rs2,
    input  logic [$clog2(NUM_FWD+1)-1:0]   fwd_sel1,
    input  logic [$clog2(NUM_FWD+1)-1:0]   fwd_sel2,
    input  logic [NUM_FWD*XLEN-1:0]        fwd_val,
    input  logic [4:0]                     rd_in,
    input  logic                           flush,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [XLEN-1:0]                result_out,
    output logic [4:0]                     rd_out,
    output logic                           busy
);

    localparam int unsigned SW       = $clog2(NUM_FWD + 1);
    localparam int unsigned CW       = $clog2(XLEN + 1);
    localparam int unsigned MUL_LAST = (MUL_LAT > 1) ? MUL_LAT - 2 : 0;
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t state, next_state;

    logic [2:0]      op_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] a_q, b_q;
    logic [XLEN-1:0] quo, rem, dvs;
    logic            neg_q, neg_r;
    logic [CW-1:0]   cnt;

    // Operand select: 0 = register file, k = forwarding source k-1, out of range = register.
    function automatic logic [XLEN-1:0] pick(input logic [SW-1:0] sel,
                                             input logic [XLEN-1:0] reg_val,
                                             input logic [NUM_FWD*XLEN-1:0] fv);
        logic [XLEN-1:0] v;
        v = reg_val;
        for (int unsigned k = 1; k <= NUM_FWD; k++) begin
            if (sel == SW'(k)) v = fv[(k-1)*XLEN +: XLEN];
        end
        return v;
    endfunction

    logic [XLEN-1:0] op1, op2;
    logic            accept;
    logic            in_div, in_sgn, in_rem;
    logic            div_zero, div_ovf, fast;
    logic            op1_neg, op2_neg;
    logic [XLEN-1:0] fast_res;

    always_comb begin
        op1      = pick(fwd_sel1, rs1, fwd_val);
        op2      = pick(fwd_sel2, rs2, fwd_val);
        in_div   = mdu_op[2];
        in_sgn   = !mdu_op[0];
        in_rem   = mdu_op[1];
        div_zero = (op2 == '0);
        div_ovf  = in_sgn && (op1 == MOST_NEG) && (op2 == '1);
        fast     = in_div && (div_zero || div_ovf);
        op1_neg  = in_sgn && op1[XLEN-1];
        op2_neg  = in_sgn && op2[XLEN-1];
        if (in_rem) fast_res = div_zero ? op1 : '0;
        else        fast_res = div_zero ? '1 : op1;
    end

    assign in_ready = (state == S_IDLE) && !flush;
    assign accept   = in_valid && in_ready;
    assign busy     = (state != S_IDLE);

    // Multiplier: both operands extended to 2*XLEN so one unsigned product covers all signednesses.
    logic [XLEN-1:0]   mul_a, mul_b, mul_res;
    logic [2:0]        mul_op;
    logic              a_sx, b_sx;
    logic [2*XLEN-1:0] mul_ae, mul_be, prod;

    always_comb begin
        mul_a   = (state == S_IDLE) ? op1 : a_q;
        mul_b   = (state == S_IDLE) ? op2 : b_q;
        mul_op  = (state == S_IDLE) ? mdu_op : op_q;
        a_sx    = ((mul_op == 3'd1) || (mul_op == 3'd2)) && mul_a[XLEN-1];
        b_sx    = (mul_op == 3'd1) && mul_b[XLEN-1];
        mul_ae  = {{XLEN{a_sx}}, mul_a};
        mul_be  = {{XLEN{b_sx}}, mul_b};
        prod    = mul_ae * mul_be;
        mul_res = (mul_op[1:0] == 2'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    // One restoring step: shift in the next dividend bit and subtract if it fits.
    logic [XLEN:0]   rem_sh, diff;
    logic [XLEN-1:0] q_fix, r_fix, fix_res;

    always_comb begin
        rem_sh  = {rem, quo[XLEN-1]};
        diff    = rem_sh - {1'b0, dvs};
        q_fix   = neg_q ? -quo : quo;
        r_fix   = neg_r ? -rem : rem;
        fix_res = op_q[1] ? r_fix : q_fix;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (!in_div)   next_state = (MUL_LAT == 1) ? S_DONE : S_MUL;
                    else if (fast) next_state = S_DONE;
                    else           next_state = S_DIV;
                end
            end
            S_MUL:  if (cnt == CW'(MUL_LAST)) next_state = S_DONE;
            S_DIV:  if (cnt == CW'(XLEN - 1)) next_state = S_FIX;
            S_FIX:  next_state = S_DONE;
            S_DONE: if (out_ready) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
        if (flush) next_state = S_IDLE;
    end

    // Datapath: capture at accept, iterate, and load the result only on entry to DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q       <= '0;
            rd_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            quo        <= '0;
            rem        <= '0;
            dvs        <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            cnt        <= '0;
            out_valid  <= 1'b0;
            result_out <= '0;
            rd_out     <= '0;
        end else begin
            out_valid <= (next_state == S_DONE);
            if (accept) begin
                op_q  <= mdu_op;
                rd_q  <= rd_in;
                a_q   <= op1;
                b_q   <= op2;
                quo   <= op1_neg ? -op1 : op1;
                dvs   <= op2_neg ? -op2 : op2;
                rem   <= '0;
                neg_q <= op1_neg ^ op2_neg;
                neg_r <= op1_neg;
                cnt   <= '0;
                if (next_state == S_DONE) begin
                    result_out <= in_div ? fast_res : mul_res;
                    rd_out     <= rd_in;
                end
            end else begin
                case (state)
                    S_MUL: begin
                        cnt <= cnt + CW'(1);
                        if (next_state == S_DONE) begin
                            result_out <= mul_res;
                            rd_out     <= rd_q;
                        end
                    end
                    S_DIV: begin
                        cnt <= cnt + CW'(1);
                        rem <= diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
                        quo <= {quo[XLEN-2:0], !diff[XLEN]};
                    end
                    S_FIX: begin
                        if (next_state == S_DONE) begin
                            result_out <= fix_res;
                            rd_out     <= rd_q;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_execute_mdu.sv
// Scoreboard bench for execute_mdu: stimulus pushes expected results, a monitor
// pops and checks value, tag and latency (cycle 0 = accept cycle) when out_valid rises.
module tb_execute_mdu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  mdu_op;
    logic [31:0] rs1, rs2;
    logic [1:0]  fwd_sel1, fwd_sel2;
    logic [63:0] fwd_val;
    logic [4:0]  rd_in;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result_out;
    logic [4:0]  rd_out;
    logic        busy;

    execute_mdu #(.XLEN(32), .NUM_FWD(2), .MUL_LAT(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .mdu_op(mdu_op), .rs1(rs1), .rs2(rs2), .fwd_sel1(fwd_sel1),
        .fwd_sel2(fwd_sel2), .fwd_val(fwd_val), .rd_in(rd_in), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .result_out(result_out),
        .rd_out(rd_out), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   vprev = 1'b0;

    localparam logic [63:0] FV = {32'd9, 32'd100};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: full check on the rising edge of out_valid, hold check while it stays up.
    always @(negedge clk) begin
        if (rst && out_valid) begin
            if (!vprev) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out_valid", 64'd1, 64'd0);
                end else begin
                    cur = sb.pop_front();
                    chk("result", result_out, cur.res);
                    chk("rd", rd_out, cur.rd);
                    chk("latency", cyc - cur.acc + 1, cur.lat);
                end
            end else begin
                chk("hold_result", result_out, cur.res);
                chk("hold_rd", rd_out, cur.rd);
                chk("hold_in_ready", in_ready, 1'b0);
            end
        end
        vprev = rst && out_valid;
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [1:0] s1, input logic [1:0] s2,
                         input logic [31:0] er, input int el, input bit push);
        int n = 0;
        @(negedge clk);
        mdu_op = op; rs1 = a; rs2 = b; rd_in = rd;
        fwd_sel1 = s1; fwd_sel2 = s2; fwd_val = FV; in_valid = 1'b1;
        #1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (push) sb.push_back('{er, rd, cyc, el});
        in_valid = 1'b0;
        mdu_op = 3'($urandom); rs1 = $urandom; rs2 = $urandom; rd_in = 5'($urandom);
        fwd_sel1 = 2'($urandom); fwd_sel2 = 2'($urandom); fwd_val = {$urandom, $urandom};
    endtask

    task automatic wait_done();
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", (sb.size() != 0 || busy), 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; in_valid = 1'b0; mdu_op = '0; rs1 = '0; rs2 = '0;
        fwd_sel1 = '0; fwd_sel2 = '0; fwd_val = '0; rd_in = '0; flush = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_result", result_out, 32'h0);
        chk("rst_rd", rd_out, 5'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);

        // Multiplies
        issue(3'd0, 32'hFFFF_FFFF, 32'd2,        5'd1, 2'd0, 2'd0, 32'hFFFF_FFFE, 2, 1'b1);
        issue(3'd3, 32'hFFFF_FFFF, 32'd2,        5'd2, 2'd0, 2'd0, 32'h0000_0001, 2, 1'b1);
        issue(3'd1, 32'hFFFF_FFFF, 32'd2,        5'd3, 2'd0, 2'd0, 32'hFFFF_FFFF, 2, 1'b1);
        issue(3'd2, 32'hFFFF_FFFF, 32'd2,        5'd4, 2'd0, 2'd0, 32'hFFFF_FFFF, 2, 1'b1);
        issue(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd5, 2'd0, 2'd0, 32'h4000_0000, 2, 1'b1);
        // Divides
        issue(3'd4, 32'hFFFF_FFF9, 32'd2,        5'd6, 2'd0, 2'd0, 32'hFFFF_FFFD, 34, 1'b1);
        issue(3'd6, 32'hFFFF_FFF9, 32'd2,        5'd7, 2'd0, 2'd0, 32'hFFFF_FFFF, 34, 1'b1);
        issue(3'd4, 32'd7, 32'hFFFF_FFFE,        5'd8, 2'd0, 2'd0, 32'hFFFF_FFFD, 34, 1'b1);
        issue(3'd6, 32'd7, 32'hFFFF_FFFE,        5'd9, 2'd0, 2'd0, 32'h0000_0001, 34, 1'b1);
        issue(3'd5, 32'hFFFF_FFFF, 32'd1,        5'd10, 2'd0, 2'd0, 32'hFFFF_FFFF, 34, 1'b1);
        // Fast paths: divide by zero and signed overflow
        issue(3'd5, 32'd5, 32'd0,                5'd11, 2'd0, 2'd0, 32'hFFFF_FFFF, 1, 1'b1);
        issue(3'd7, 32'd5, 32'd0,                5'd12, 2'd0, 2'd0, 32'h0000_0005, 1, 1'b1);
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 2'd0, 2'd0, 32'h8000_0000, 1, 1'b1);
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 2'd0, 2'd0, 32'h0000_0000, 1, 1'b1);
        issue(3'd4, 32'd0, 32'd0,                5'd15, 2'd0, 2'd0, 32'hFFFF_FFFF, 1, 1'b1);
        // Forwarding: source 1 = 9 on op1; out-of-range select keeps rs1, source 0 = 100 on op2
        issue(3'd5, 32'd3, 32'd3,                5'd16, 2'd2, 2'd0, 32'd3, 34, 1'b1);
        issue(3'd0, 32'd6, 32'd7,                5'd17, 2'd3, 2'd1, 32'd600, 2, 1'b1);
        wait_done();

        // Backpressure: result and tag must hold for 5 cycles with in_ready low
        issue(3'd7, 32'd100, 32'd7, 5'd18, 2'd0, 2'd0, 32'd2, 34, 1'b1);
        out_ready = 1'b0;
        begin
            int n = 0;
            while (!out_valid && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("bp_valid_seen", out_valid, 1'b1);
        end
        repeat (5) @(negedge clk);
        out_ready = 1'b1;
        issue(3'd5, 32'd100, 32'd7, 5'd19, 2'd0, 2'd0, 32'd14, 34, 1'b1);
        wait_done();

        // Flush during divide cycle 10, with an offered op in the flush cycle
        issue(3'd4, 32'd1000, 32'd3, 5'd20, 2'd0, 2'd0, 32'd0, 34, 1'b0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        in_valid = 1'b1; mdu_op = 3'd0; rs1 = 32'd1; rs2 = 32'd1; fwd_sel1 = '0; fwd_sel2 = '0;
        #1;
        chk("flush_in_ready", in_ready, 1'b0);
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_busy", busy, 1'b0);
        chk("flush_out_valid", out_valid, 1'b0);
        issue(3'd4, 32'd1000, 32'd3, 5'd21, 2'd0, 2'd0, 32'd333, 34, 1'b1);
        wait_done();

        // Reset mid-operation, then a fresh operation
        issue(3'd5, 32'd50, 32'd5, 5'd22, 2'd0, 2'd0, 32'd0, 34, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_result", result_out, 32'h0);
        chk("mid_rst_rd", rd_out, 5'd0);
        @(negedge clk);
        rst = 1'b1;
        issue(3'd0, 32'hFFFF_FFFF, 32'd2, 5'd23, 2'd0, 2'd0, 32'hFFFF_FFFE, 2, 1'b1);
        issue(3'd5, 32'd50, 32'd5, 5'd24, 2'd0, 2'd0, 32'd10, 34, 1'b1);
        wait_done();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
